// File: rtl/ntt_bf_stage.sv
// Radix-2 NTT butterfly stage: four mod-Q butterflies per 8-lane beat, 3-cycle pipeline.
// Defining NTT_BF_GS_EN adds the `inv` port and the Gentleman-Sande (inverse) butterfly.
package ntt_bf_pkg;
    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 16;
    typedef logic [LANES-1:0][LANE_W-1:0] lane_t;
endpackage

module ntt_bf_stage
    import ntt_bf_pkg::*;
#(
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned Q       = 7681
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  lane_t              lane_in,
    input  logic               nttend,
`ifdef NTT_BF_GS_EN
    input  logic               inv,
`endif
    input  logic               tw_we,
    input  logic [4:0]         tw_addr,
    input  logic [COEFF_W-1:0] tw_data,
    output lane_t              lane_out,
    output logic               valid_out
);

    localparam int unsigned PAIRS  = 4;
    localparam int unsigned TW_N   = 32;
    localparam int unsigned SUM_W  = COEFF_W + 1;
    localparam int unsigned DIF_W  = COEFF_W + 2;
    localparam int unsigned PROD_W = 2 * COEFF_W;

    typedef logic [PAIRS-1:0][COEFF_W-1:0] pair_vec_t;

    function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= SUM_W'(Q)) sum = sum - SUM_W'(Q);
        return sum[COEFF_W-1:0];
    endfunction

    function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [DIF_W-1:0] dif;
        dif = {2'b00, a} - {2'b00, b};
        if (dif[DIF_W-1]) dif = dif + DIF_W'(Q);
        return dif[COEFF_W-1:0];
    endfunction

    function automatic logic [COEFF_W-1:0] mod_mul(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] rem;
        prod = PROD_W'(a) * PROD_W'(b);
        rem  = prod % PROD_W'(Q);
        return COEFF_W'(rem);
    endfunction

    logic [COEFF_W-1:0] tw_tab [TW_N];
    logic [2:0]         beat;

    logic      s1_v, s2_v;
    pair_vec_t s1_x, s1_y, s1_w;
    pair_vec_t s2_x, s2_t;
    pair_vec_t x_c, y_c, w_c, t_c;
    lane_t     res_c;
`ifdef NTT_BF_GS_EN
    logic      s1_inv, s2_inv;
`endif

    // Twiddle table; a write lands at the edge, so a beat sampled on that edge sees the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TW_N; i++) tw_tab[i] <= COEFF_W'(1);
        end else if (tw_we) begin
            tw_tab[tw_addr] <= tw_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        beat <= 3'd0;
        else if (nttend)   beat <= 3'd0;
        else if (valid_in) beat <= beat + 3'd1;
    end

    // Stage-1 operands: forward passes (a, b); inverse pre-computes (a+b, a-b)
    always_comb begin
        x_c = '0;
        y_c = '0;
        w_c = '0;
        for (int k = 0; k < PAIRS; k++) begin
            w_c[2'(k)] = tw_tab[{beat, 2'(k)}];
            x_c[2'(k)] = COEFF_W'(lane_in[3'(2 * k)]);
            y_c[2'(k)] = COEFF_W'(lane_in[3'(2 * k + 1)]);
`ifdef NTT_BF_GS_EN
            if (inv) begin
                x_c[2'(k)] = mod_add(COEFF_W'(lane_in[3'(2 * k)]), COEFF_W'(lane_in[3'(2 * k + 1)]));
                y_c[2'(k)] = mod_sub(COEFF_W'(lane_in[3'(2 * k)]), COEFF_W'(lane_in[3'(2 * k + 1)]));
            end
`endif
        end
    end

    always_comb begin
        t_c = '0;
        for (int k = 0; k < PAIRS; k++) t_c[2'(k)] = mod_mul(s1_w[2'(k)], s1_y[2'(k)]);
    end

    always_comb begin
        res_c = '0;
        for (int k = 0; k < PAIRS; k++) begin
            res_c[3'(2 * k)]     = LANE_W'(mod_add(s2_x[2'(k)], s2_t[2'(k)]));
            res_c[3'(2 * k + 1)] = LANE_W'(mod_sub(s2_x[2'(k)], s2_t[2'(k)]));
`ifdef NTT_BF_GS_EN
            if (s2_inv) begin
                res_c[3'(2 * k)]     = LANE_W'(s2_x[2'(k)]);
                res_c[3'(2 * k + 1)] = LANE_W'(s2_t[2'(k)]);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            valid_out <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_w      <= '0;
            s2_x      <= '0;
            s2_t      <= '0;
            lane_out  <= '0;
`ifdef NTT_BF_GS_EN
            s1_inv    <= 1'b0;
            s2_inv    <= 1'b0;
`endif
        end else begin
            s1_v      <= valid_in;
            s2_v      <= s1_v;
            valid_out <= s2_v;
            if (valid_in) begin
                s1_x <= x_c;
                s1_y <= y_c;
                s1_w <= w_c;
`ifdef NTT_BF_GS_EN
                s1_inv <= inv;
`endif
            end
            if (s1_v) begin
                s2_x <= s1_x;
                s2_t <= t_c;
`ifdef NTT_BF_GS_EN
                s2_inv <= s1_inv;
`endif
            end
            if (s2_v) lane_out <= res_c;
        end
    end

endmodule

// File: tb/tb_ntt_bf_stage.sv
// Scoreboard bench for ntt_bf_stage: arithmetic reference model, directed and random beats.
// Also exercises the inverse butterfly when NTT_BF_GS_EN is defined.
module tb_ntt_bf_stage;
    import ntt_bf_pkg::*;

    localparam int unsigned Q = 7681;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    lane_t       lane_in;
    logic        nttend;
    logic        tw_we;
    logic [4:0]  tw_addr;
    logic [15:0] tw_data;
    lane_t       lane_out;
    logic        valid_out;
`ifdef NTT_BF_GS_EN
    logic        inv;
`endif

    always #5 clk = ~clk;

    ntt_bf_stage #(.COEFF_W(16), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .lane_in(lane_in), .nttend(nttend),
`ifdef NTT_BF_GS_EN
        .inv(inv),
`endif
        .tw_we(tw_we), .tw_addr(tw_addr), .tw_data(tw_data),
        .lane_out(lane_out), .valid_out(valid_out)
    );

    typedef struct { lane_t lane; int unsigned due; } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    lane_t       last_out = '0;
    int unsigned mtab[32];
    int unsigned mbeat;
    lane_t       dir_mask, dir_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference butterflies written directly from the modular-arithmetic definition
    function automatic lane_t model_bf(input lane_t in, input int unsigned bt, input bit iv);
        lane_t r;
        longint a, b, w, p;
        for (int k = 0; k < 4; k++) begin
            a = longint'(in[2*k]);
            b = longint'(in[2*k+1]);
            w = longint'(mtab[bt*4+k]);
            if (!iv) begin
                p = (w * b) % Q;
                r[2*k]   = 16'((a + p) % Q);
                r[2*k+1] = 16'((a - p + Q) % Q);
            end else begin
                r[2*k]   = 16'((a + b) % Q);
                r[2*k+1] = 16'((((a - b + Q) % Q) * w) % Q);
            end
        end
        return r;
    endfunction

    function automatic lane_t rand_lane();
        lane_t r;
        for (int i = 0; i < 8; i++) r[i] = 16'($urandom_range(Q - 1, 0));
        return r;
    endfunction

    function automatic lane_t mk8(input int unsigned v0, v1, v2, v3, v4, v5, v6, v7);
        lane_t r;
        r[0] = 16'(v0); r[1] = 16'(v1); r[2] = 16'(v2); r[3] = 16'(v3);
        r[4] = 16'(v4); r[5] = 16'(v5); r[6] = 16'(v6); r[7] = 16'(v7);
        return r;
    endfunction

    // One clock of stimulus; expectation uses the table/counter state before this edge
    task automatic step(input bit v, input lane_t ln, input bit ne, input bit we,
                        input logic [4:0] ad, input int unsigned dt, input bit iv);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in = v;
        lane_in  = ln;
        nttend   = ne;
        tw_we    = we;
        tw_addr  = ad;
        tw_data  = 16'(dt);
`ifdef NTT_BF_GS_EN
        inv = iv;
`endif
        if (v) begin
            e.lane = (model_bf(ln, mbeat, iv) & ~dir_mask) | (dir_exp & dir_mask);
            e.due  = cyc + 3;
            sb.push_back(e);
        end
        if (we) mtab[ad] = dt;
        if (ne) mbeat = 0;
        else if (v) mbeat = (mbeat + 1) % 8;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 5'd0, 0, 1'b0);
    endtask

    task automatic beat(input lane_t ln);
        step(1'b1, ln, 1'b0, 1'b0, 5'd0, 0, 1'b0);
    endtask

    task automatic wr(input int unsigned ad, input int unsigned dt);
        step(1'b0, '0, 1'b0, 1'b1, 5'(ad), dt, 1'b0);
    endtask

    // Monitor: pops the scoreboard on valid_out, otherwise checks hold / reset values
    always @(negedge clk) begin
        if (!rst_n) begin
            n_chk++;
            if (valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid: got %b want 0", valid_out);
            end
            n_chk++;
            if (lane_out !== '0) begin
                n_fail++;
                $display("FAIL reset_lane: got %h want 0", lane_out);
            end
        end else if (valid_out === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d want no output", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (lane_out !== mon_e.lane) begin
                    n_fail++;
                    $display("FAIL lane_out: got %h want %h", lane_out, mon_e.lane);
                end
                n_chk++;
                if (cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL latency: got cycle %0d want %0d", cyc, mon_e.due);
                end
            end
        end else begin
            n_chk++;
            if (valid_out !== 1'b0 || lane_out !== last_out) begin
                n_fail++;
                $display("FAIL hold: got valid=%b lane=%h want valid=0 lane=%h",
                         valid_out, lane_out, last_out);
            end
        end
        last_out = lane_out;
    end

    initial begin
        lane_t ln;
        rst_n = 1'b0; valid_in = 1'b0; lane_in = '0; nttend = 1'b0;
        tw_we = 1'b0; tw_addr = '0; tw_data = '0;
`ifdef NTT_BF_GS_EN
        inv = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mtab[i] = 1;
        mbeat = 0;
        dir_mask = '0;
        dir_exp  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Identity twiddles, edge values around Q
        dir_mask = '1;
        dir_exp  = mk8(8, 2, 3, 7680, 0, 0, 0, 7679);
        beat(mk8(5, 3, 1, 2, 0, 0, 7680, 1));
        dir_mask = '0;
        idle(4);

        // Twiddle 2 on beat 0 pair 0
        step(1'b0, '0, 1'b1, 1'b0, 5'd0, 0, 1'b0);
        wr(0, 2);
        ln = rand_lane();
        ln[0] = 16'd10;
        ln[1] = 16'd7680;
        dir_mask = '0;
        dir_mask[0] = 16'hffff; dir_mask[1] = 16'hffff;
        dir_exp[0] = 16'd8; dir_exp[1] = 16'd12;
        beat(ln);
        dir_mask = '0;
        wr(0, 1);
        idle(4);

        // Distinct beat-3 twiddles across a counter wrap
        step(1'b0, '0, 1'b1, 1'b0, 5'd0, 0, 1'b0);
        for (int k = 0; k < 4; k++) wr(12 + k, 1000 + 1111 * k);
        for (int i = 0; i < 12; i++) beat(rand_lane());
        idle(4);

        // nttend together with the 5th beat restarts at beat 0
        for (int k = 0; k < 4; k++) wr(k, 3000 + 17 * k);
        step(1'b0, '0, 1'b1, 1'b0, 5'd0, 0, 1'b0);
        for (int i = 0; i < 4; i++) beat(rand_lane());
        step(1'b1, rand_lane(), 1'b1, 1'b0, 5'd0, 0, 1'b0);
        beat(rand_lane());
        idle(4);

        // Gap pattern 1,0,1,1
        beat(rand_lane());
        idle(1);
        beat(rand_lane());
        beat(rand_lane());
        idle(5);

        // Write and read of the same entry in one cycle returns the old value
        step(1'b1, rand_lane(), 1'b0, 1'b1, 5'({3'(mbeat), 2'd1}), 4242, 1'b0);
        beat(rand_lane());
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit iv;
            iv = 1'b0;
`ifdef NTT_BF_GS_EN
            iv = 1'($urandom_range(1, 0));
`endif
            step($urandom_range(3, 0) != 0, rand_lane(), $urandom_range(19, 0) == 0,
                 $urandom_range(3, 0) == 0, 5'($urandom_range(31, 0)),
                 $urandom_range(Q - 1, 0), iv);
        end
        idle(4);

        // Reset mid-flight discards beats and restores identity twiddles
        for (int i = 0; i < 32; i++) wr(i, $urandom_range(Q - 1, 2));
        beat(rand_lane());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid_in = 1'b0; nttend = 1'b0; tw_we = 1'b0;
        sb.delete();
        for (int i = 0; i < 32; i++) mtab[i] = 1;
        mbeat = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        for (int i = 0; i < 8; i++) beat(rand_lane());
        idle(5);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending beats want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_bf_stage.md
# ntt_bf_stage

Radix-2 NTT butterfly stage: four parallel Cooley-Tukey butterflies, one for each adjacent lane pair of an 8-coefficient `lane_t` beat, with modulo-Q arithmetic. It sits directly downstream of the input commutor network and consumes its `lane_out`/`valid_out` stream. Twiddle factors come from a writable 32-entry table indexed by an internal beat counter. The block is fully pipelined, accepts one beat per cycle and has no backpressure.

## Interface
- `COEFF_W`, 16: coefficient width; must equal the per-coefficient width of `lane_t` in defines.sv.
- `Q`, 7681: prime modulus; must satisfy Q < 2^COEFF_W.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `valid_in`  in  1  `lane_in` holds a valid beat this cycle.
- `lane_in`  in  lane_t  8 coefficients, each < Q.
- `nttend`  in  1  single-cycle pulse marking the end of the current transform.
- `tw_we`  in  1  twiddle table write strobe.
- `tw_addr`  in  5  write address {beat[2:0], pair[1:0]}.
- `tw_data`  in  COEFF_W  twiddle value, < Q.
- `lane_out`  out  lane_t  butterfly results.
- `valid_out`  out  1  `lane_out` is valid this cycle.

## Operation
- Lane pair k (k = 0..3) is (a = lane[2k], b = lane[2k+1]).
- w = table[{beat, k}].
- Forward butterfly: lane_out[2k] = (a + w·b) mod Q; lane_out[2k+1] = (a − w·b) mod Q.
- All results lie in [0, Q−1].
- Arithmetic widths:
  - Product w·b is 2·COEFF_W bits, reduced with a full mod-Q operation to t < Q.
  - Sum a + t is COEFF_W+1 bits; subtract Q once if the sum ≥ Q.
  - Difference a − t is computed signed; add Q once if negative.
- Beat counter `beat` (3 bits):
  - Reset value 0.
  - Increments on every accepted `valid_in` and wraps from 7 to 0.
  - `nttend` forces it to 0 at the next edge. When `valid_in` and `nttend` arrive together, the beat uses the current count and the counter then becomes 0.
- Twiddle table:
  - 32 × COEFF_W flops; every entry resets to 1 (identity twiddle).
  - A write is visible to a beat entering the stage on the cycle after the write edge.
  - A write and a read of the same entry in the same cycle return the old value.
- Out-of-range inputs (≥ Q) give undefined results; no checking is done.

## Timing
- Latency is 3 cycles: a beat with `valid_in` at edge n appears with `valid_out` at edge n+3.
  - Stage 1: register a, b and w.
  - Stage 2: register t = w·b mod Q.
  - Stage 3: register the add/sub results.
- Throughput is 1 beat per cycle; gaps in `valid_in` pass through unchanged to `valid_out`.
- Stage data registers load only when their stage valid bit is set. `lane_out` holds its last value while `valid_out` = 0.
- Reset values: `valid_out` = 0, `lane_out` = all zeros, all internal valid bits = 0, `beat` = 0.
- Reset asserted mid-operation discards all in-flight beats, and no `valid_out` follows. It also restores the twiddle table to all ones.

## Configuration
- `NTT_BF_GS_EN` defined:
  - Adds input port `inv` (1 bit), sampled with `valid_in` and carried down the pipeline with the beat.
  - With `inv` = 1 the stage computes the Gentleman-Sande butterfly: lane_out[2k] = (a + b) mod Q, lane_out[2k+1] = ((a − b) mod Q)·w mod Q.
  - Latency stays 3 cycles: the add/sub moves into stage 1 and the multiply into stages 2–3.
- Not defined: there is no `inv` port and the stage is forward-only.

## Test plan
- Reset, identity twiddles, one beat lane_in = {5,3,1,2,0,0,7680,1} → 3 cycles later `valid_out` = 1 with lane_out = {8,2,3,7680,0,0,0,7679}.
- Write tw_addr = 0, tw_data = 2, then a beat with lane[0] = 10, lane[1] = 7680 → lane_out[0] = 8, lane_out[1] = 12. The other pairs use w = 1.
- Write distinct twiddles to beat-3 entries, send 12 consecutive beats → beats 3 and 11 use them (counter wraps after 7); every other beat gives identity results.
- Send 5 beats, pulse `nttend` together with the 5th, then send 1 beat → that beat uses beat-0 twiddles.
- Send the pattern valid 1,0,1,1 → `valid_out` shows 1,0,1,1 delayed 3 cycles, with `lane_out` held during the gap.
- Assert `rst_n` low 1 cycle after a valid beat → `valid_out` stays 0, `lane_out` = 0, and the table is back to 1s.
